// File: rtl/cpu_timer_pkg.sv
// Shared definitions for the CPU timer peripheral: register offsets,
// CTRL/STATUS bit positions and the address window size used by the MMU.
package cpu_timer_pkg;

    localparam int TIMER_SIZE = 8;

    typedef enum logic [2:0] {
        TIMER_CTRL     = 3'd0,
        TIMER_PRESCALE = 3'd1,
        TIMER_COUNT    = 3'd2,
        TIMER_RELOAD   = 3'd3,
        TIMER_STATUS   = 3'd4,
        TIMER_FREE_LO  = 3'd5,
        TIMER_FREE_HI  = 3'd6,
        TIMER_RSVD     = 3'd7
    } timer_reg_e;

    localparam int CTRL_RUN_BIT       = 0;
    localparam int CTRL_AUTO_BIT      = 1;
    localparam int CTRL_IRQEN_BIT     = 2;
    localparam int STATUS_EXPIRED_BIT = 0;

endpackage

// File: rtl/cpu_timer_if.sv
// CPU data bus as seen by a memory-mapped peripheral: request side driven by
// the CPU/MMU, one-cycle acknowledge with registered read data from the slave.
interface memory_bus #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  write_enable;
    logic                  enable;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_ready;

    modport master (
        output address, data_in, write_enable, enable,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, write_enable, enable,
        output data_out, data_ready
    );
endinterface

// File: rtl/cpu_timer_prescaler.sv
// Prescaler for the timer: counts 0..prescale while running and pulses tick
// in the cycle it wraps. Stopped or cleared, it sits at zero.
module cpu_timer_prescaler #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] prescale,
    output logic                  tick
);
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == prescale);

    // Next prescaler value: hold at zero when idle or cleared, wrap on tick
    always_comb begin
        cnt_d = cnt_q;
        if (!run || clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prescaler state register
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/cpu_timer.sv
// Memory-mapped timer: bus decode, register file, prescaled down-counter with
// auto-reload and sticky expiry, level interrupt and free-running cycle counter.
module cpu_timer
    import cpu_timer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int FREE_WIDTH = 2 * DATA_WIDTH
) (
    input  logic     clock,
    input  logic     reset,
    memory_bus.slave bus,
    output logic     irq
);
    logic                  run_q, run_d, auto_q, auto_d, irqen_q, irqen_d;
    logic [DATA_WIDTH-1:0] prescale_q, prescale_d, count_q, count_d;
    logic [DATA_WIDTH-1:0] reload_q, reload_d, snap_q, snap_d;
    logic                  expired_q, expired_d, irq_q, irq_d;
    logic [FREE_WIDTH-1:0] free_q, free_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;

    timer_reg_e offset;
    logic       accept, wr_en, rd_en, tick, expire;
    logic       unused_addr;

    // A new access is taken only when no acknowledge is outstanding, which
    // paces a held enable to one access every two cycles.
    assign accept      = bus.enable && !ack_q;
    assign wr_en       = accept && bus.write_enable;
    assign rd_en       = accept && !bus.write_enable;
    assign offset      = timer_reg_e'(bus.address[2:0]);
    assign unused_addr = ^bus.address[ADDR_WIDTH-1:3];
    assign expire      = tick && (count_q == '0);

    cpu_timer_prescaler #(.DATA_WIDTH(DATA_WIDTH)) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .run      (run_q),
        .clear    (wr_en && (offset == TIMER_PRESCALE)),
        .prescale (prescale_q),
        .tick     (tick)
    );

    // Read data mux; values are pre-write since registers update at accept
    always_comb begin
        rd_mux = '0;
        case (offset)
            TIMER_CTRL: begin
                rd_mux[CTRL_RUN_BIT]   = run_q;
                rd_mux[CTRL_AUTO_BIT]  = auto_q;
                rd_mux[CTRL_IRQEN_BIT] = irqen_q;
            end
            TIMER_PRESCALE: rd_mux = prescale_q;
            TIMER_COUNT:    rd_mux = count_q;
            TIMER_RELOAD:   rd_mux = reload_q;
            TIMER_STATUS:   rd_mux[STATUS_EXPIRED_BIT] = expired_q;
            TIMER_FREE_LO:  rd_mux = free_q[DATA_WIDTH-1:0];
            TIMER_FREE_HI:  rd_mux = snap_q;
            default:        rd_mux = '0;
        endcase
    end

    // Next-state for registers: hardware timer updates first, bus writes
    // layered on top so they win, and expiry set applied last over W1C.
    always_comb begin
        run_d      = run_q;
        auto_d     = auto_q;
        irqen_d    = irqen_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        reload_d   = reload_q;
        expired_d  = expired_q;
        snap_d     = snap_q;

        if (tick) begin
            if (!expire) begin
                count_d = count_q - 1'b1;
            end else if (auto_q) begin
                count_d = reload_q;
            end else begin
                run_d = 1'b0;
            end
        end

        if (wr_en) begin
            case (offset)
                TIMER_CTRL: begin
                    run_d   = bus.data_in[CTRL_RUN_BIT];
                    auto_d  = bus.data_in[CTRL_AUTO_BIT];
                    irqen_d = bus.data_in[CTRL_IRQEN_BIT];
                end
                TIMER_PRESCALE: prescale_d = bus.data_in;
                TIMER_COUNT:    count_d    = bus.data_in;
                TIMER_RELOAD:   reload_d   = bus.data_in;
                TIMER_STATUS: begin
                    if (bus.data_in[STATUS_EXPIRED_BIT]) begin
                        expired_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (expire) begin
            expired_d = 1'b1;
        end

        if (rd_en && (offset == TIMER_FREE_LO)) begin
            snap_d = free_q[FREE_WIDTH-1:DATA_WIDTH];
        end
    end

    // Bus response, interrupt level and free counter next-state
    always_comb begin
        ack_d   = accept;
        rdata_d = rd_en ? rd_mux : '0;
        irq_d   = expired_q && irqen_q;
        free_d  = free_q + 1'b1;
    end

    // State registers; reset drops any pending acknowledge
    always_ff @(posedge clock) begin
        if (reset) begin
            run_q      <= 1'b0;
            auto_q     <= 1'b0;
            irqen_q    <= 1'b0;
            prescale_q <= '0;
            count_q    <= '0;
            reload_q   <= '0;
            expired_q  <= 1'b0;
            snap_q     <= '0;
            free_q     <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            run_q      <= run_d;
            auto_q     <= auto_d;
            irqen_q    <= irqen_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            expired_q  <= expired_d;
            snap_q     <= snap_d;
            free_q     <= free_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.data_out   = rdata_q;
    assign bus.data_ready = ack_q;
    assign irq            = irq_q;
endmodule

// File: tb/tb_cpu_timer.sv
// Testbench for cpu_timer: directed scenarios plus randomized timer setups
// checked against closed-form expectations derived from tick arithmetic.
module tb_cpu_timer;
    import cpu_timer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic irq;

    memory_bus bus ();

    cpu_timer dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int last_rst = 0;
    int total = 0;
    int bad = 0;

    // Edge numbering: after edge k, cyc==k; last_rst is the last edge seen with reset high
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) last_rst <= cyc + 1;
    end

    // One bus access started #1 after an edge; returns #1 after the edge that ends the ack
    task automatic xfer(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                        output logic [15:0] rdv, output int acc, output bit ok);
        bus.address      = addr;
        bus.data_in      = wd;
        bus.write_enable = we;
        bus.enable       = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        bus.enable       = 1'b0;
        bus.write_enable = 1'b0;
        rdv = bus.data_out;
        ok  = (bus.data_ready === 1'b1);
        @(posedge clk); #1;
        ok  = ok && (bus.data_ready === 1'b0) && (bus.data_out === 16'h0);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] wd, output int acc);
        logic [15:0] r;
        bit ok;
        xfer(1'b1, addr, wd, r, acc, ok);
    endtask

    task automatic rd(input logic [15:0] addr, output logic [15:0] r, output int acc);
        bit ok;
        xfer(1'b0, addr, 16'h0, r, acc, ok);
    endtask

    // Idle until the next driven access will be accepted at edge 'target'
    task automatic wait_to(input int target);
        while (cyc < target - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic stop_timer();
        int a;
        wr(16'(TIMER_CTRL), 16'h0, a);
        wr(16'(TIMER_STATUS), 16'h1, a);
    endtask

    // COUNT value seen by a read accepted d edges after the run-start edge
    function automatic int exp_count(int d, int p, int c, int r, bit ar);
        int n, m;
        n = (d - 1) / (p + 1);
        if (n <= c) return c - n;
        if (!ar) return 0;
        m = n - c - 1;
        return r - (m % (r + 1));
    endfunction

    task automatic test_reset();
        logic [15:0] r;
        int acc, expv;
        bit ok;
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.write_enable = 1'b0;
        bus.address = 16'h0002;
        bus.data_in = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", bus.data_ready); end
        total++;
        if (bus.data_out !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h want=0000", bus.data_out); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
        bus.enable = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 16'(i), 16'h0, r, acc, ok);
            expv = (i == 5) ? (acc - 1 - last_rst) : 0;
            total++;
            if (!ok) begin bad++; $display("FAIL reset_handshake off=%0d got=bad_ack want=one_cycle_ack", i); end
            total++;
            if (r !== 16'(expv)) begin bad++; $display("FAIL reset_read off=%0d got=%h want=%h", i, r, 16'(expv)); end
        end
    endtask

    task automatic test_oneshot();
        logic [15:0] r;
        int a, e0;
        stop_timer();
        wr(16'(TIMER_PRESCALE), 16'd3, a);
        wr(16'(TIMER_COUNT), 16'd2, a);
        wr(16'(TIMER_CTRL), 16'h1, e0);
        wait_to(e0 + 4);  rd(16'(TIMER_COUNT), r, a);
        total++; if (r !== 16'd2) begin bad++; $display("FAIL oneshot_count_t4 got=%h want=0002", r); end
        wait_to(e0 + 6);  rd(16'(TIMER_COUNT), r, a);
        total++; if (r !== 16'd1) begin bad++; $display("FAIL oneshot_count_t6 got=%h want=0001", r); end
        wait_to(e0 + 9);  rd(16'(TIMER_COUNT), r, a);
        total++; if (r !== 16'd0) begin bad++; $display("FAIL oneshot_count_t9 got=%h want=0000", r); end
        wait_to(e0 + 11); rd(16'(TIMER_STATUS), r, a);
        total++; if (r !== 16'd0) begin bad++; $display("FAIL oneshot_status_t11 got=%h want=0000", r); end
        wait_to(e0 + 13); rd(16'(TIMER_STATUS), r, a);
        total++; if (r !== 16'd1) begin bad++; $display("FAIL oneshot_status_t13 got=%h want=0001", r); end
        wait_to(e0 + 15); rd(16'(TIMER_CTRL), r, a);
        total++; if (r !== 16'd0) begin bad++; $display("FAIL oneshot_run_clear got=%h want=0000", r); end
        wait_to(e0 + 17); rd(16'(TIMER_COUNT), r, a);
        total++; if (r !== 16'd0) begin bad++; $display("FAIL oneshot_count_hold got=%h want=0000", r); end
    endtask

    task automatic test_autoreload();
        logic [15:0] r;
        int a, e0, rise;
        stop_timer();
        wr(16'(TIMER_PRESCALE), 16'd0, a);
        wr(16'(TIMER_RELOAD), 16'd5, a);
        wr(16'(TIMER_COUNT), 16'd0, a);
        wr(16'(TIMER_CTRL), 16'h7, e0);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL auto_irq_before got=%b want=0", irq); end
        @(posedge clk); #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL auto_irq_rise got=%b want=1", irq); end
        wr(16'(TIMER_STATUS), 16'h1, a);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL auto_irq_w1c got=%b want=0", irq); end
        for (int k = 1; k <= 2; k++) begin
            rise = -1;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (irq === 1'b1) begin rise = cyc; break; end
            end
            total++;
            if (rise != e0 + 2 + 6 * k) begin
                bad++; $display("FAIL auto_period%0d got=%0d want=%0d", k, rise - e0, 2 + 6 * k);
            end
            if (k == 1) begin
                wr(16'(TIMER_STATUS), 16'h1, a);
                total++; if (irq !== 1'b0) begin bad++; $display("FAIL auto_irq_w1c2 got=%b want=0", irq); end
            end
        end
        wr(16'(TIMER_CTRL), 16'h3, a);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL auto_irq_en_off got=%b want=0", irq); end
        rd(16'(TIMER_STATUS), r, a);
        total++; if (r !== 16'd1) begin bad++; $display("FAIL auto_sticky got=%h want=0001", r); end
    endtask

    task automatic test_w1c_collision();
        logic [15:0] r;
        int a, e0;
        stop_timer();
        wr(16'(TIMER_PRESCALE), 16'd7, a);
        wr(16'(TIMER_RELOAD), 16'h0100, a);
        wr(16'(TIMER_COUNT), 16'd0, a);
        wr(16'(TIMER_CTRL), 16'h7, e0);
        wait_to(e0 + 8);
        wr(16'(TIMER_STATUS), 16'h1, a);
        rd(16'(TIMER_STATUS), r, a);
        total++; if (r !== 16'd1) begin bad++; $display("FAIL w1c_collide got=%h want=0001", r); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_collide_irq got=%b want=1", irq); end
        wr(16'(TIMER_STATUS), 16'h1, a);
        rd(16'(TIMER_STATUS), r, a);
        total++; if (r !== 16'd0) begin bad++; $display("FAIL w1c_plain got=%h want=0000", r); end
    endtask

    task automatic test_count_write_tick();
        logic [15:0] r;
        int a, e0;
        stop_timer();
        wr(16'(TIMER_PRESCALE), 16'd7, a);
        wr(16'(TIMER_COUNT), 16'h0040, a);
        wr(16'(TIMER_CTRL), 16'h1, e0);
        wait_to(e0 + 8);
        wr(16'(TIMER_COUNT), 16'h0010, a);
        rd(16'(TIMER_COUNT), r, a);
        total++; if (r !== 16'h0010) begin bad++; $display("FAIL count_wr_tick got=%h want=0010", r); end
        wait_to(e0 + 17);
        rd(16'(TIMER_COUNT), r, a);
        total++; if (r !== 16'h000f) begin bad++; $display("FAIL count_after_tick got=%h want=000f", r); end
    endtask

    task automatic test_reserved_and_decode();
        logic [15:0] r;
        int a;
        bit ok;
        stop_timer();
        xfer(1'b1, 16'h0007, 16'hffff, r, a, ok);
        total++; if (!ok) begin bad++; $display("FAIL rsvd_write_ack got=bad_ack want=one_cycle_ack"); end
        rd(16'h0007, r, a);
        total++; if (r !== 16'h0) begin bad++; $display("FAIL rsvd_read got=%h want=0000", r); end
        wr(16'(TIMER_CTRL), 16'hfff8, a);
        rd(16'(TIMER_CTRL), r, a);
        total++; if (r !== 16'h0) begin bad++; $display("FAIL ctrl_rsvd_bits got=%h want=0000", r); end
        wr(16'ha5a3, 16'h1234, a);
        rd(16'h0003, r, a);
        total++; if (r !== 16'h1234) begin bad++; $display("FAIL addr_alias_wr got=%h want=1234", r); end
        rd(16'hfff3, r, a);
        total++; if (r !== 16'h1234) begin bad++; $display("FAIL addr_alias_rd got=%h want=1234", r); end
    endtask

    task automatic test_back_to_back();
        bus.address = 16'(TIMER_RELOAD);
        bus.write_enable = 1'b0;
        bus.enable = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.data_ready !== 1'b1 || bus.data_out !== 16'h1234) begin
            bad++; $display("FAIL b2b_first got=%b/%h want=1/1234", bus.data_ready, bus.data_out); end
        @(posedge clk); #1;
        total++; if (bus.data_ready !== 1'b0 || bus.data_out !== 16'h0) begin
            bad++; $display("FAIL b2b_gap got=%b/%h want=0/0000", bus.data_ready, bus.data_out); end
        @(posedge clk); #1;
        total++; if (bus.data_ready !== 1'b1 || bus.data_out !== 16'h1234) begin
            bad++; $display("FAIL b2b_second got=%b/%h want=1/1234", bus.data_ready, bus.data_out); end
        bus.enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] r;
        int a, e0, p, c, rl, gap, d, expv, x;
        bit ar, en, expired, exp_irq;
        for (int it = 0; it < 6; it++) begin
            p  = int'($urandom_range(0, 4));
            c  = int'($urandom_range(0, 12));
            rl = int'($urandom_range(0, 9));
            ar = 1'($urandom_range(0, 1));
            en = 1'($urandom_range(0, 1));
            stop_timer();
            wr(16'(TIMER_PRESCALE), 16'(p), a);
            wr(16'(TIMER_RELOAD), 16'(rl), a);
            wr(16'(TIMER_COUNT), 16'(c), a);
            wr(16'(TIMER_CTRL), 16'(1 + 2 * int'(ar) + 4 * int'(en)), e0);
            for (int k = 0; k < 6; k++) begin
                gap = int'($urandom_range(0, 8));
                repeat (gap) begin @(posedge clk); #1; end
                x = cyc;
                exp_irq = en && ((x - 1 - e0) >= (c + 1) * (p + 1));
                total++;
                if (irq !== exp_irq) begin
                    bad++; $display("FAIL rand_irq it=%0d t=%0d got=%b want=%b", it, x - e0, irq, exp_irq);
                end
                rd(16'(k % 3 == 0 ? TIMER_COUNT : (k % 3 == 1 ? TIMER_STATUS : TIMER_CTRL)), r, a);
                d = a - e0;
                expired = ((d - 1) / (p + 1)) >= (c + 1);
                if (k % 3 == 0)      expv = exp_count(d, p, c, rl, ar);
                else if (k % 3 == 1) expv = int'(expired);
                else                 expv = 4 * int'(en) + (ar ? 3 : (expired ? 0 : 1));
                total++;
                if (r !== 16'(expv)) begin
                    bad++; $display("FAIL rand_read it=%0d sel=%0d p=%0d c=%0d r=%0d ar=%b t=%0d got=%h want=%h",
                                    it, k % 3, p, c, rl, ar, d, r, 16'(expv));
                end
            end
        end
    endtask

    task automatic test_free();
        logic [15:0] lo, hi;
        int a_lo, a;
        stop_timer();
        while (cyc - last_rst < 70000) begin @(posedge clk); #1; end
        rd(16'(TIMER_FREE_LO), lo, a_lo);
        rd(16'(TIMER_FREE_HI), hi, a);
        total++;
        if ({hi, lo} !== 32'(a_lo - 1 - last_rst)) begin
            bad++; $display("FAIL free_value got=%h want=%h", {hi, lo}, 32'(a_lo - 1 - last_rst));
        end
        total++; if (hi !== 16'd1) begin bad++; $display("FAIL free_hi_wrap got=%h want=0001", hi); end
        repeat (40) begin @(posedge clk); #1; end
        rd(16'(TIMER_FREE_HI), hi, a);
        total++; if (hi !== 16'd1) begin bad++; $display("FAIL free_snap_hold got=%h want=0001", hi); end
        wr(16'(TIMER_FREE_LO), 16'h0, a);
        rd(16'(TIMER_FREE_LO), lo, a_lo);
        total++;
        if (lo !== 16'(a_lo - 1 - last_rst)) begin
            bad++; $display("FAIL free_readonly got=%h want=%h", lo, 16'(a_lo - 1 - last_rst));
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.write_enable = 1'b0;
        bus.address = 16'h0;
        bus.data_in = 16'h0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_w1c_collision();
        test_count_write_tick();
        test_reserved_and_decode();
        test_back_to_back();
        test_random();
        test_free();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
